// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch unit.
//
// Contents:
//   DEFAULT_RESET_ADDR : default first word address fetched after reset
//   fetch_state_t      : fetch FSM states (IDLE, REQ, WAIT, DRAIN)
//   fetch_entry_t      : instruction queue entry {instr, pc}
//   next_word()        : word-address increment, wraps 32'hFFFF_FFFF -> 0

package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Addresses are word addresses, so sequential fetch is a plain +1 that
  // wraps naturally at 32 bits.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- synchronous FIFO holding fetched instructions for decode.
//
// Parameters:
//   DEPTH      : number of entries (power of two, 2..16)
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : empties the queue; wins over push and pop
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (contents undefined when empty)
//   full/empty : occupancy flags
//   count      : number of valid entries (0..DEPTH)

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   slots [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  // A full queue can still accept a push when the head leaves on the same
  // edge, which keeps the count unchanged.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap
  // by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset; only slots behind the pointers are read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch unit: issues word reads to instruction
// memory (one outstanding at a time), queues the returned words with their
// addresses and hands them to decode in order. A redirect flushes the queue
// and restarts fetch at a new address.
//
// Parameters:
//   QDEPTH       : instruction queue entries (power of two, 2..16)
//   RESET_ADDR   : first word address fetched after reset
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   redirect       : one-cycle pulse, restart fetch at redirect_addr
//   redirect_addr  : new word address
//   imem_req       : read request valid
//   imem_addr      : requested word address
//   imem_gnt       : request accepted this cycle
//   imem_rvalid    : read data valid (one per granted request)
//   imem_rdata     : instruction word
//   instr_valid    : queue head valid for decode
//   instr_ready    : decode accepts head
//   instr          : head instruction (0 when not valid)
//   instr_pc       : head word address (0 when not valid)
//   stall_cnt      : only with INSTR_FETCH_STALL_CNT_EN defined; saturating
//                    count of cycles decode was ready but nothing was valid

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          QDEPTH     = 4,
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef INSTR_FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_addr;
  logic [31:0]   pending_pc;
  logic          grant;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [CW:0]   count_after_push;
  logic          room_after_push;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;

  assign grant = imem_req && imem_gnt;

  // Redirect beats pop: the head being accepted is discarded by the flush.
  assign q_pop = instr_valid && instr_ready && !redirect;

  // Occupancy once the response arriving now is pushed; deciding whether
  // to request again from this value keeps one slot reserved for every
  // outstanding read, so the queue can never overflow.
  assign count_after_push = {1'b0, q_count} + (CW+1)'(1) - (CW+1)'(q_pop);
  assign room_after_push  = count_after_push < (CW+1)'(QDEPTH);

  assign q_in = '{instr: imem_rdata, pc: pending_pc};

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign instr_valid = !q_empty;
  assign instr       = q_empty ? 32'd0 : q_head.instr;
  assign instr_pc    = q_empty ? 32'd0 : q_head.pc;
  assign imem_addr   = fetch_addr;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and request/push strobes. DRAIN waits out a response whose
  // request was overtaken by a redirect; if that response lands in the
  // same cycle as the redirect it is simply dropped and fetch resumes.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    q_push     = 1'b0;
    case (state)
      IDLE: begin
        if (redirect || !q_full) state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_next = redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        q_push = imem_rvalid && !redirect;
        if (imem_rvalid) state_next = (redirect || room_after_push) ? REQ : IDLE;
        else if (redirect) state_next = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch address moves only on a grant or a redirect, which keeps
  // imem_addr stable while a request waits for its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= RESET_ADDR;
      pending_pc <= '0;
    end else begin
      if (grant) pending_pc <= fetch_addr;
      if (redirect)   fetch_addr <= redirect_addr;
      else if (grant) fetch_addr <= next_word(fetch_addr);
    end
  end

`ifdef INSTR_FETCH_STALL_CNT_EN
  // Decode-starvation counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (instr_ready && !instr_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- self-checking bench for instr_fetch.
// A memory responder returns mem_word(addr) after a configurable latency;
// a scoreboard expects decode to see consecutive word addresses starting at
// the reset or redirect address, each carrying mem_word(pc).

module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef INSTR_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp;
  int n_fail;
  int pop_cnt;
  int grant_cnt;
  int gnt_mode;
  int lat_min;
  int lat_max;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  instr_fetch #(
    .QDEPTH(4),
    .RESET_ADDR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc)
`ifdef INSTR_FETCH_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} ^ 32'h0F0F_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge, then move to one time unit
  // before the next rising edge where outputs are sampled.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] raddr);
    @(negedge clk);
    instr_ready   = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    #4;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = 32'd0;
    repeat (3) @(negedge clk);
    #4;
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
`ifdef INSTR_FETCH_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance (at least one cycle) until instr_valid, bounded.
  task automatic waitValid(input string name, input logic rdy, input int maxc);
    int n;
    n = 0;
    do begin
      applyStimulus(rdy, 1'b0, 32'h0);
      n++;
    end while (!instr_valid && n < maxc);
    checkOutput({name, "_valid"}, instr_valid, 1);
  endtask

  // Advance until a grant is about to happen at the coming edge, bounded.
  task automatic waitGrant(input string name, input logic rdy, input int maxc);
    int n;
    n = 0;
    do begin
      applyStimulus(rdy, 1'b0, 32'h0);
      n++;
    end while (!(imem_req && imem_gnt) && n < maxc);
    checkOutput({name, "_grant"}, imem_req && imem_gnt, 1);
  endtask

  // Memory responder: exactly one response per grant after lat_min..lat_max
  // cycles. Also checks that no request is granted while one is in flight.
  initial begin
    bit          rsp_pending;
    int          rsp_delay;
    logic [31:0] rsp_addr;
    rsp_pending = 1'b0;
    rsp_delay   = 0;
    rsp_addr    = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rst) begin
        rsp_pending = 1'b0;
        imem_gnt    = 1'b0;
      end else begin
        if (rsp_pending) begin
          if (rsp_delay == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rsp_addr);
            rsp_pending = 1'b0;
          end else begin
            rsp_delay--;
          end
        end
        case (gnt_mode)
          0:       imem_gnt = 1'b1;
          1:       imem_gnt = ($urandom_range(0, 9) < 7);
          default: imem_gnt = 1'b0;
        endcase
        if (imem_req && imem_gnt) begin
          checkOutput("one_outstanding", {31'b0, rsp_pending}, 0);
          rsp_pending = 1'b1;
          rsp_addr    = imem_addr;
          rsp_delay   = $urandom_range(lat_min - 1, lat_max - 1);
          grant_cnt++;
        end
      end
    end
  end

  // Scoreboard and protocol monitor, sampled just before each rising edge.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] hold_addr;
    bit          hold_chk;
    bit          prev_redir;
    exp_pc = 32'h0;
    hold_addr = 32'h0;
    hold_chk = 1'b0;
    prev_redir = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        exp_pc = 32'h0;
        hold_chk = 1'b0;
        prev_redir = 1'b0;
      end else begin
        if (prev_redir) checkOutput("valid_after_redirect", instr_valid, 0);
        if (hold_chk) begin
          checkOutput("req_hold", imem_req, 1);
          checkOutput("addr_hold", imem_addr, hold_addr);
        end
        hold_chk  = imem_req && !imem_gnt;
        hold_addr = redirect ? redirect_addr : imem_addr;
        if (redirect) begin
          exp_pc = redirect_addr;
        end else if (instr_valid && instr_ready) begin
          checkOutput("pop_pc", instr_pc, exp_pc);
          checkOutput("pop_instr", instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd1;
          pop_cnt++;
        end
        prev_redir = redirect;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g0;
    int p0;
    n_cmp = 0;
    n_fail = 0;
    pop_cnt = 0;
    grant_cnt = 0;
    gnt_mode = 0;
    lat_min = 1;
    lat_max = 1;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_addr = 32'h0;
    instr_ready = 1'b0;

    // Startup with 1-cycle memory: one instruction every two cycles.
    //            rdy   req   addr   valid pc
    vecs[0] = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd1, 1'b0, 32'd0};
    vecs[2] = '{1'b1, 1'b1, 32'd1, 1'b1, 32'd0};
    vecs[3] = '{1'b1, 1'b0, 32'd2, 1'b0, 32'd0};
    vecs[4] = '{1'b1, 1'b1, 32'd2, 1'b1, 32'd1};
    vecs[5] = '{1'b1, 1'b0, 32'd3, 1'b0, 32'd0};
    vecs[6] = '{1'b1, 1'b1, 32'd3, 1'b1, 32'd2};
    vecs[7] = '{1'b1, 1'b0, 32'd4, 1'b0, 32'd0};
    vecs[8] = '{1'b1, 1'b1, 32'd4, 1'b1, 32'd3};
    vecs[9] = '{1'b1, 1'b0, 32'd5, 1'b0, 32'd0};

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rdy, 1'b0, 32'h0);
      checkOutput($sformatf("seq%0d_req", i), imem_req, vecs[i].exp_req);
      checkOutput($sformatf("seq%0d_addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("seq%0d_valid", i), instr_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("seq%0d_pc", i), instr_pc, vecs[i].exp_pc);
        checkOutput($sformatf("seq%0d_instr", i), instr, mem_word(vecs[i].exp_pc));
      end
    end

    // Decode stalled: queue fills to exactly four, then drains in order.
    doReset();
    g0 = grant_cnt;
    repeat (20) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("full_req", imem_req, 0);
    checkOutput("full_grants", grant_cnt - g0, 4);
    checkOutput("full_valid", instr_valid, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("drain%0d_valid", k), instr_valid, 1);
      checkOutput($sformatf("drain%0d_pc", k), instr_pc, k);
    end

    // Redirect while a response is outstanding: queued and in-flight
    // instructions are dropped, delivery resumes at 0x100.
    doReset();
    lat_min = 3;
    lat_max = 3;
    waitValid("wait_first", 1'b0, 20);
    waitGrant("wait_second", 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_flush_valid", instr_valid, 0);
    waitValid("redir_new", 1'b1, 30);
    checkOutput("redir_new_pc", instr_pc, 32'h0000_0100);
    checkOutput("redir_new_instr", instr, mem_word(32'h0000_0100));
    lat_min = 1;
    lat_max = 1;

    // Address wrap at the top of the word space.
    doReset();
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
    waitValid("wrap_a", 1'b1, 20);
    checkOutput("wrap_a_pc", instr_pc, 32'hFFFF_FFFF);
    waitValid("wrap_b", 1'b1, 20);
    checkOutput("wrap_b_pc", instr_pc, 32'h0000_0000);

    // Grant withheld: address holds, redirect in the third cycle retargets
    // the pending request on the next cycle.
    doReset();
    gnt_mode = 2;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("nogrant0_req", imem_req, 1);
    checkOutput("nogrant0_addr", imem_addr, 32'h0);
    for (int k = 1; k < 5; k++) begin
      applyStimulus(1'b1, (k == 2), 32'h0000_2000);
      checkOutput($sformatf("nogrant%0d_req", k), imem_req, 1);
      checkOutput($sformatf("nogrant%0d_addr", k), imem_addr, (k <= 2) ? 32'h0 : 32'h0000_2000);
    end
    gnt_mode = 0;
    waitValid("nogrant_resume", 1'b1, 20);
    checkOutput("nogrant_resume_pc", instr_pc, 32'h0000_2000);

    // Randomized traffic against the scoreboard.
    doReset();
    gnt_mode = 1;
    lat_min = 1;
    lat_max = 3;
    p0 = pop_cnt;
    for (int c = 0; c < 1500; c++) begin
      logic        rdy;
      logic        redir;
      logic [31:0] raddr;
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 39) == 0);
      raddr = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFFC + $urandom_range(0, 3)) : $urandom;
      applyStimulus(rdy, redir, raddr);
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("random_progress", (pop_cnt - p0) > 100, 1);

    // Reset in the middle of traffic.
    doReset();
    gnt_mode = 0;
    lat_min = 1;
    lat_max = 1;

`ifdef INSTR_FETCH_STALL_CNT_EN
    // Decode ready with nothing to deliver for seven cycles.
    gnt_mode = 2;
    repeat (7) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall_cnt", stall_cnt, 32'd7);
    gnt_mode = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
